image_packer: RTL and testbench

Transmitter for the `layers` image input port. It accepts a narrow pixel stream, one `IMG_WIDTH` word per beat, and packs `GROUP_NB` pixels per output beat onto `image_bus`. It pads the final beat of each dot-product vector with zeros and asserts `image_last` on that beat. The vector length is set over the shared cfg bus; the block sits between the image buffer reader and `layers`.

---
 rtl/image_packer.sv | 169 ++++++++++++++++
 tb/tb_image_packer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_packer.sv
// image_packer: packs a narrow pixel stream into GROUP_NB-lane beats for the
// layers image port, zero-padding and flagging the final beat of each vector.
module image_packer #(
  parameter int                    GROUP_NB   = 4,
  parameter int                    IMG_WIDTH  = 16,
  parameter int                    CFG_DWIDTH = 32,
  parameter int                    CFG_AWIDTH = 5,
  parameter logic [CFG_AWIDTH-1:0] CFG_ADDR   = 5'd6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic [IMG_WIDTH-1:0]          pixel,
  input  logic                          pixel_val,
  output logic                          pixel_rdy,
  output logic [GROUP_NB*IMG_WIDTH-1:0] image_bus,
  output logic                          image_last,
  output logic                          image_val,
  input  logic                          image_rdy
);

  localparam int LANE_W = $clog2(GROUP_NB);
  localparam int BUS_W  = GROUP_NB * IMG_WIDTH;

  // Configuration and vector-tracking state.
  logic [15:0]       len_q, len_d;
  logic [15:0]       remain_q, remain_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              open_q, open_d;

  // Packing stage: lane registers double as the held group when pack_full is set.
  logic [BUS_W-1:0]  lanes_q, lanes_d;
  logic              pack_full_q, pack_full_d;
  logic              pack_last_q, pack_last_d;

  // Output stage.
  logic [BUS_W-1:0]  bus_q, bus_d;
  logic              last_q, last_d;
  logic              val_q, val_d;
  logic              rdy_q, rdy_d;

  // Datapath helpers.
  logic              cfg_hit;
  logic              pix_fire;
  logic              out_free;
  logic [LANE_W-1:0] cur_lane;
  logic [15:0]       cur_remain;
  logic              grp_done;
  logic              grp_last;
  logic [BUS_W-1:0]  group_bus;

  // Upper config bits carry nothing for this block.
  logic unused_cfg;
  assign unused_cfg = ^cfg_data[CFG_DWIDTH-1:16];

  // Decode handshakes and assemble the group as it would look after this pixel.
  always_comb begin
    cfg_hit    = cfg_valid && (cfg_addr == CFG_ADDR);
    pix_fire   = pixel_val && rdy_q;
    out_free   = !val_q || image_rdy;
    // A closed vector starts from lane 0 with the current configured length.
    cur_lane   = open_q ? lane_q : '0;
    cur_remain = open_q ? remain_q : len_q;
    grp_last   = (cur_remain == 16'd1);
    grp_done   = (cur_lane == LANE_W'(GROUP_NB - 1)) || grp_last;
    group_bus  = '0;
    // Lanes below the write point keep earlier pixels; lanes above read as zero,
    // which gives the padding of a short final group for free.
    for (int k = 0; k < GROUP_NB; k++) begin
      if (k < int'(cur_lane)) begin
        group_bus[k*IMG_WIDTH +: IMG_WIDTH] = lanes_q[k*IMG_WIDTH +: IMG_WIDTH];
      end else if (k == int'(cur_lane)) begin
        group_bus[k*IMG_WIDTH +: IMG_WIDTH] = pixel;
      end
    end
  end

  // Next-state logic for packing, hold buffer, output beat and ready.
  always_comb begin
    // NOTE: every variable gets a default first so no path through this block infers a latch.
    len_d       = len_q;
    remain_d    = remain_q;
    lane_d      = lane_q;
    open_d      = open_q;
    lanes_d     = lanes_q;
    pack_full_d = pack_full_q;
    pack_last_d = pack_last_q;
    bus_d       = bus_q;
    last_d      = last_q;
    val_d       = val_q;

    if (cfg_hit) begin
      len_d = cfg_data[15:0];
    end

    if (pix_fire) begin
      lanes_d  = group_bus;
      remain_d = cur_remain - 16'd1;
      if (grp_done) begin
        lane_d = '0;
        open_d = !grp_last;
      end else begin
        lane_d = cur_lane + LANE_W'(1);
        open_d = 1'b1;
      end
    end

    // A held group has priority; ready is low while holding, so no new
    // group can complete in the same cycle.
    if (out_free) begin
      if (pack_full_q) begin
        bus_d       = lanes_q;
        last_d      = pack_last_q;
        val_d       = 1'b1;
        pack_full_d = 1'b0;
      end else if (pix_fire && grp_done) begin
        bus_d  = group_bus;
        last_d = grp_last;
        val_d  = 1'b1;
      end else begin
        val_d  = 1'b0;
      end
    end else if (pix_fire && grp_done) begin
      pack_full_d = 1'b1;
      pack_last_d = grp_last;
    end

    rdy_d = (len_d != 16'd0) && !pack_full_d;
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= '0;
      remain_q    <= '0;
      lane_q      <= '0;
      open_q      <= 1'b0;
      // NOTE: lane registers are reset too so a discarded partial group can never resurface.
      lanes_q     <= '0;
      pack_full_q <= 1'b0;
      pack_last_q <= 1'b0;
      bus_q       <= '0;
      last_q      <= 1'b0;
      val_q       <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      len_q       <= len_d;
      remain_q    <= remain_d;
      lane_q      <= lane_d;
      open_q      <= open_d;
      lanes_q     <= lanes_d;
      pack_full_q <= pack_full_d;
      pack_last_q <= pack_last_d;
      bus_q       <= bus_d;
      last_q      <= last_d;
      val_q       <= val_d;
      rdy_q       <= rdy_d;
    end
  end

  assign pixel_rdy  = rdy_q;
  assign image_bus  = bus_q;
  assign image_last = last_q;
  assign image_val  = val_q;

endmodule

// File: tb/tb_image_packer.sv
// tb_image_packer: directed stimulus for image_packer with a vector-level
// reference model and a per-cycle output checker.
module tb_image_packer;

  localparam int G  = 4;
  localparam int W  = 16;
  localparam int BW = G * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   cfg_data;
  logic [4:0]    cfg_addr;
  logic          cfg_valid;
  logic [W-1:0]  pixel;
  logic          pixel_val;
  logic          pixel_rdy;
  logic [BW-1:0] image_bus;
  logic          image_last;
  logic          image_val;
  logic          image_rdy;

  image_packer #(
    .GROUP_NB  (G),
    .IMG_WIDTH (W),
    .CFG_DWIDTH(32),
    .CFG_AWIDTH(5),
    .CFG_ADDR  (5'd6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_data  (cfg_data),
    .cfg_addr  (cfg_addr),
    .cfg_valid (cfg_valid),
    .pixel     (pixel),
    .pixel_val (pixel_val),
    .pixel_rdy (pixel_rdy),
    .image_bus (image_bus),
    .image_last(image_last),
    .image_val (image_val),
    .image_rdy (image_rdy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW-1:0] bus;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a vector is a list of pixels chopped into groups of G;
  // each group is emitted when full or when the vector ends.
  logic [15:0]   m_len;
  int            m_vec_len;
  int            m_count;
  logic [15:0]   m_grp[$];
  logic          prev_val, prev_rdy, prev_last;
  logic [BW-1:0] prev_bus;
  beat_t         got, nb;

  always @(negedge clk) begin
    if (rst) begin
      m_len    = '0;
      m_count  = 0;
      m_grp.delete();
      exp_q.delete();
      prev_val = 1'b0;
    end else begin
      if (prev_val && !prev_rdy) begin
        check("hold_val",  64'(image_val),  64'd1);
        check("hold_bus",  image_bus,       prev_bus);
        check("hold_last", 64'(image_last), 64'(prev_last));
      end
      if (image_val && image_rdy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_beat: got bus 0x%0h last %0d, expected no beat", image_bus, image_last);
        end else begin
          got = exp_q.pop_front();
          check("beat_bus",  image_bus,       got.bus);
          check("beat_last", 64'(image_last), 64'(got.last));
        end
      end
      if (pixel_val && pixel_rdy) begin
        if (m_count == 0) m_vec_len = int'(m_len);
        m_grp.push_back(pixel);
        m_count++;
        if (m_grp.size() == G || m_count == m_vec_len) begin
          nb.bus = '0;
          for (int i = 0; i < m_grp.size(); i++) nb.bus[i*W +: W] = m_grp[i];
          nb.last = (m_count == m_vec_len);
          exp_q.push_back(nb);
          m_grp.delete();
          if (nb.last) m_count = 0;
        end
      end
      if (cfg_valid && cfg_addr == 5'd6) m_len = cfg_data[15:0];
      prev_val  = image_val;
      prev_rdy  = image_rdy;
      prev_bus  = image_bus;
      prev_last = image_last;
    end
  end

  // Advance n clock edges and settle just past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [4:0] addr, input logic [15:0] len);
    cfg_addr  = addr;
    cfg_data  = {16'hDEAD, len};
    cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
  endtask

  // Offer one pixel and return just after the edge that accepts it.
  task automatic send_pixel(input logic [15:0] p);
    int waited;
    waited    = 0;
    pixel     = p;
    pixel_val = 1'b1;
    @(negedge clk);
    while (!pixel_rdy && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!pixel_rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL pixel_accept_timeout: pixel_rdy stayed 0 for pixel 0x%0h, expected 1", p);
    end
    step(1);
    pixel_val = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cfg_data  = '0;
    cfg_addr  = '0;
    cfg_valid = 1'b0;
    pixel     = '0;
    pixel_val = 1'b0;
    image_rdy = 1'b1;
    step(2);
    rst = 1'b0;

    // Reset state.
    check("rst_pixel_rdy",  64'(pixel_rdy),  64'd0);
    check("rst_image_val",  64'(image_val),  64'd0);
    check("rst_image_last", 64'(image_last), 64'd0);
    check("rst_image_bus",  image_bus,       64'd0);

    // Len 4: single full beat, one cycle after the 4th pixel.
    cfg_write(5'd6, 16'd4);
    check("t1_rdy_after_cfg", 64'(pixel_rdy), 64'd1);
    send_pixel(16'h0100);
    send_pixel(16'h0200);
    send_pixel(16'h0300);
    check("t1_no_early_beat", 64'(image_val), 64'd0);
    send_pixel(16'h0400);
    check("t1_val",  64'(image_val),  64'd1);
    check("t1_bus",  image_bus,       64'h0400_0300_0200_0100);
    check("t1_last", 64'(image_last), 64'd1);
    step(2);

    // Len 6: full beat then padded last beat; next vector restarts at lane 0.
    cfg_write(5'd6, 16'd6);
    for (int i = 1; i <= 4; i++) send_pixel(16'(i << 8));
    check("t2_b0_bus",  image_bus,       64'h0400_0300_0200_0100);
    check("t2_b0_last", 64'(image_last), 64'd0);
    send_pixel(16'h0500);
    send_pixel(16'h0600);
    check("t2_b1_bus",  image_bus,       64'h0000_0000_0600_0500);
    check("t2_b1_last", 64'(image_last), 64'd1);
    for (int i = 7; i <= 10; i++) send_pixel(16'(i << 8));
    check("t2_v2_bus",  image_bus,       64'h0A00_0900_0800_0700);
    check("t2_v2_last", 64'(image_last), 64'd0);
    send_pixel(16'h0B00);
    send_pixel(16'h0C00);
    check("t2_v2_tail", image_bus, 64'h0000_0000_0C00_0B00);
    step(2);

    // Len 8 under backpressure: first beat holds, second group held, ready drops.
    cfg_write(5'd6, 16'd8);
    image_rdy = 1'b0;
    for (int i = 1; i <= 8; i++) send_pixel(16'(i << 8));
    check("t3_rdy_low_in_hold", 64'(pixel_rdy), 64'd0);
    check("t3_val_held",        64'(image_val), 64'd1);
    check("t3_bus_held",        image_bus,      64'h0400_0300_0200_0100);
    check("t3_last_held",       64'(image_last), 64'd0);
    step(2);
    image_rdy = 1'b1;
    step(1);
    check("t3_b1_bus",  image_bus,       64'h0800_0700_0600_0500);
    check("t3_b1_last", 64'(image_last), 64'd1);
    check("t3_rdy_back", 64'(pixel_rdy), 64'd1);
    step(1);
    check("t3_val_drops", 64'(image_val), 64'd0);
    step(2);

    // Disabled after reset; wrong address ignored; len 3 with negative pixels.
    pulse_reset();
    step(2);
    check("t4_rdy_len0", 64'(pixel_rdy), 64'd0);
    check("t4_no_beat",  64'(image_val), 64'd0);
    cfg_write(5'd5, 16'd3);
    check("t4_wrong_addr", 64'(pixel_rdy), 64'd0);
    cfg_write(5'd6, 16'd3);
    check("t4_rdy_len3", 64'(pixel_rdy), 64'd1);
    send_pixel(16'hFB00);
    send_pixel(16'hFA00);
    send_pixel(16'hF900);
    check("t4_bus",  image_bus,       64'h0000_F900_FA00_FB00);
    check("t4_last", 64'(image_last), 64'd1);
    step(2);

    // Len 4 with a len-2 write mid-vector: current vector keeps 4 lanes.
    cfg_write(5'd6, 16'd4);
    send_pixel(16'h0100);
    send_pixel(16'h0200);
    cfg_write(5'd6, 16'd2);
    send_pixel(16'h0300);
    send_pixel(16'h0400);
    check("t5_bus",  image_bus,       64'h0400_0300_0200_0100);
    check("t5_last", 64'(image_last), 64'd1);
    send_pixel(16'h0A00);
    send_pixel(16'h0B00);
    check("t5_next_bus",  image_bus,       64'h0000_0000_0B00_0A00);
    check("t5_next_last", 64'(image_last), 64'd1);

    // Cfg write on the same cycle as a first pixel: that vector uses the old length.
    cfg_addr  = 5'd6;
    cfg_data  = 32'h0000_0004;
    cfg_valid = 1'b1;
    send_pixel(16'h1100);
    cfg_valid = 1'b0;
    send_pixel(16'h1200);
    check("t5_same_cycle_bus",  image_bus,       64'h0000_0000_1200_1100);
    check("t5_same_cycle_last", 64'(image_last), 64'd1);
    for (int i = 1; i <= 4; i++) send_pixel(16'h2000 | 16'(i << 8));
    check("t5_newlen_bus",  image_bus,       64'h2400_2300_2200_2100);
    check("t5_newlen_last", 64'(image_last), 64'd1);
    step(2);

    // Reset mid-vector discards the partial group and the length.
    cfg_write(5'd6, 16'd4);
    send_pixel(16'h0100);
    send_pixel(16'h0200);
    pulse_reset();
    check("t6_rdy",  64'(pixel_rdy),  64'd0);
    check("t6_val",  64'(image_val),  64'd0);
    check("t6_last", 64'(image_last), 64'd0);
    check("t6_bus",  image_bus,       64'd0);
    step(3);
    check("t6_rdy_stays_low", 64'(pixel_rdy), 64'd0);
    check("t6_no_beat",       64'(image_val), 64'd0);
    cfg_write(5'd6, 16'd4);
    for (int i = 1; i <= 4; i++) send_pixel(16'h3000 | 16'(i << 8));
    check("t6_fresh_bus",  image_bus,       64'h3400_3300_3200_3100);
    check("t6_fresh_last", 64'(image_last), 64'd1);
    step(3);

    check("all_beats_delivered", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
